// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared constants and types for the write-back register file and its
// pending-write scoreboard.
package wb_regfile_scoreboard_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_CNT_W  = 2;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [WB_ADDR_W-1:0] reg_idx_t;
    typedef logic [WB_DATA_W-1:0] data_word_t;

endpackage

// File: rtl/wb_regfile_scoreboard_cnt.sv
// Saturating up/down counter tracking how many writers to one register are
// still in flight. One increment (issue) and two decrements (write-back,
// squash) may arrive in the same cycle and are combined into a net change.
// The error output pulses for the cycle whose update would leave the range.
module reg_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_sq,
    output logic [CNT_W-1:0] count,
    output logic             error
);

    localparam int W = CNT_W + 2;
    localparam logic [W-1:0] MAX = W'((1 << CNT_W) - 1);

    logic [W-1:0]     up;
    logic [W-1:0]     down;
    logic [W-1:0]     diff;
    logic [CNT_W-1:0] next_count;

    // Net change computed in a wider unsigned domain; comparing up/down first
    // detects underflow without needing signed arithmetic.
    always_comb begin
        up         = W'(count) + W'(inc);
        down       = W'(dec_wb) + W'(dec_sq);
        diff       = up - down;
        error      = 1'b0;
        next_count = count;
        if (up < down) begin
            next_count = '0;
            error      = 1'b1;
        end else if (diff > MAX) begin
            next_count = '1;
            error      = 1'b1;
        end else begin
            next_count = diff[CNT_W-1:0];
        end
    end

    // Counter state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file written by the WB stage, read by ID through two
// bypassed combinational ports, with a per-register in-flight writer
// scoreboard that raises the ID stall on read-after-write hazards.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic              useReg1,
    input  logic              useReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              issueValid,
    input  logic              issueRegWrite,
    input  logic [ADDR_W-1:0] issueDest,
    input  logic              squashValid,
    input  logic [ADDR_W-1:0] squashDest,
    output logic              stall,
    output logic              scoreError
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]                regs [NUM_REGS];
    logic [NUM_REGS-1:0][CNT_W-1:0]   counts;
    logic [NUM_REGS-1:0]              cnt_err;
    logic                             wb_active;
    logic                             bypass1;
    logic                             bypass2;
    logic                             pend1;
    logic                             pend2;

    assign wb_active  = regWrite && (writeReg != ZERO_IDX);
    assign counts[0]  = '0;
    assign cnt_err[0] = 1'b0;

    // Register 0 has no counter: it is hardwired to zero and never pending.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc;
        logic dec_wb;
        logic dec_sq;

        assign inc    = issueValid && issueRegWrite && (issueDest == ADDR_W'(r));
        assign dec_wb = regWrite && (writeReg == ADDR_W'(r));
        assign dec_sq = squashValid && (squashDest == ADDR_W'(r));

        reg_scoreboard_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (inc),
            .dec_wb  (dec_wb),
            .dec_sq  (dec_sq),
            .count   (counts[r]),
            .error   (cnt_err[r])
        );
    end

    // Register file commit from WB; entry 0 is never written so it stays zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[writeReg] <= writeData;
        end
    end

    // Read ports: r0 forces zero, a same-cycle WB to the source is forwarded.
    always_comb begin
        bypass1   = wb_active && (writeReg == readReg1);
        bypass2   = wb_active && (writeReg == readReg2);
        readData1 = regs[readReg1];
        readData2 = regs[readReg2];
        if (readReg1 == ZERO_IDX) begin
            readData1 = '0;
        end else if (bypass1) begin
            readData1 = writeData;
        end
        if (readReg2 == ZERO_IDX) begin
            readData2 = '0;
        end else if (bypass2) begin
            readData2 = writeData;
        end
    end

    // A writer retiring this cycle is covered by the bypass, so it is removed
    // from the pending count; (count - bypass) != 0 reduces to count != bypass.
    always_comb begin
        pend1 = counts[readReg1] != CNT_W'(bypass1);
        pend2 = counts[readReg2] != CNT_W'(bypass2);
        stall = (useReg1 && pend1) || (useReg2 && pend2);
    end

    // Sticky scoreboard error: any counter over/underflow until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scoreError <= 1'b0;
        end else if (|cnt_err) begin
            scoreError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Self-checking bench for wb_regfile_scoreboard: a hand-computed vector table,
// directed multi-cycle sequences and randomized traffic checked against an
// array-based model of the register file and in-flight writer counts.
module tb_wb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        useReg1;
    logic        useReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        issueValid;
    logic        issueRegWrite;
    logic [4:0]  issueDest;
    logic        squashValid;
    logic [4:0]  squashDest;
    logic        stall;
    logic        scoreError;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_rf [32];
    int          model_cnt [32];
    bit          model_err;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        u1;
        logic        u2;
        logic        iv;
        logic        irw;
        logic [4:0]  id;
        logic        sv;
        logic [4:0]  sd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t vecs [11];

    wb_regfile_scoreboard dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .regWrite      (regWrite),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .readReg1      (readReg1),
        .readReg2      (readReg2),
        .useReg1       (useReg1),
        .useReg2       (useReg2),
        .readData1     (readData1),
        .readData2     (readData2),
        .issueValid    (issueValid),
        .issueRegWrite (issueRegWrite),
        .issueDest     (issueDest),
        .squashValid   (squashValid),
        .squashDest    (squashDest),
        .stall         (stall),
        .scoreError    (scoreError)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (regWrite && writeReg == idx) return writeData;
        return model_rf[idx];
    endfunction

    function automatic bit model_pend(input logic [4:0] idx);
        int retiring;
        retiring = (regWrite && writeReg == idx && idx != 5'd0) ? 1 : 0;
        return (model_cnt[idx] - retiring) != 0;
    endfunction

    function automatic bit model_stall();
        return (useReg1 && model_pend(readReg1)) || (useReg2 && model_pend(readReg2));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            model_rf[i]  = 32'h0;
            model_cnt[i] = 0;
        end
        model_err = 1'b0;
    endtask

    // Apply the current inputs' effect on the model, as the clock edge will.
    task automatic model_clock();
        int n;
        for (int r = 1; r < 32; r++) begin
            n = model_cnt[r];
            if (issueValid && issueRegWrite && issueDest == r) n = n + 1;
            if (regWrite && writeReg == r) n = n - 1;
            if (squashValid && squashDest == r) n = n - 1;
            if (n > 3) begin
                n = 3;
                model_err = 1'b1;
            end
            if (n < 0) begin
                n = 0;
                model_err = 1'b1;
            end
            model_cnt[r] = n;
        end
        if (regWrite && writeReg != 5'd0) model_rf[writeReg] = writeData;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2,
                                 input logic iv, input logic irw, input logic [4:0] id,
                                 input logic sv, input logic [4:0] sd);
        regWrite      = rw;
        writeReg      = wr;
        writeData     = wd;
        readReg1      = r1;
        readReg2      = r2;
        useReg1       = u1;
        useReg2       = u2;
        issueValid    = iv;
        issueRegWrite = irw;
        issueDest     = id;
        squashValid   = sv;
        squashDest    = sd;
        #2;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " readData1"}, readData1, model_read(readReg1));
        checkVal({tag, " readData2"}, readData2, model_read(readReg2));
        checkVal({tag, " stall"}, {31'b0, stall}, {31'b0, model_stall()});
        checkVal({tag, " scoreError"}, {31'b0, scoreError}, {31'b0, model_err});
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        idle();
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Issue a writer to r while ID reads r as source 1.
    task automatic issue_reading(input logic [4:0] r, input logic exp_stall, input string tag);
        applyStimulus(1'b0, 5'd0, 32'h0, r, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, r, 1'b0, 5'd0);
        checkVal({tag, " stall"}, {31'b0, stall}, {31'b0, exp_stall});
        checkOutput(tag);
        tick();
    endtask

    // Retire a write-back to r while ID reads r as source 1.
    task automatic wb_reading(input logic [4:0] r, input logic [31:0] d, input logic exp_stall, input string tag);
        applyStimulus(1'b1, r, d, r, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkVal({tag, " stall"}, {31'b0, stall}, {31'b0, exp_stall});
        checkVal({tag, " bypass"}, readData1, d);
        checkOutput(tag);
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h12345678, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h12345678, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};

        reset_n = 1'b0;
        model_clear();
        idle();
        do_reset();

        checkVal("reset readData1", readData1, 32'h0);
        checkVal("reset stall", {31'b0, stall}, 32'h0);
        checkVal("reset scoreError", {31'b0, scoreError}, 32'h0);

        // Hand-computed vector table: write/read, r0, bypass, RAW stall.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2,
                          vecs[i].u1, vecs[i].u2, vecs[i].iv, vecs[i].irw, vecs[i].id,
                          vecs[i].sv, vecs[i].sd);
            checkVal($sformatf("vec%0d readData1", i), readData1, vecs[i].e1);
            checkVal($sformatf("vec%0d readData2", i), readData2, vecs[i].e2);
            checkVal($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].es});
            checkVal($sformatf("vec%0d scoreError", i), {31'b0, scoreError}, {31'b0, vecs[i].ee});
            tick();
        end

        // Three writers to r4, squash one, retire two.
        issue_reading(5'd4, 1'b0, "r4 issue1");
        issue_reading(5'd4, 1'b1, "r4 issue2");
        issue_reading(5'd4, 1'b1, "r4 issue3");
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4);
        checkVal("r4 squash stall", {31'b0, stall}, 32'h1);
        checkOutput("r4 squash");
        tick();
        wb_reading(5'd4, 32'h00000044, 1'b1, "r4 wb1");
        wb_reading(5'd4, 32'h00000055, 1'b0, "r4 wb2");
        idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkVal("r4 drained stall", {31'b0, stall}, 32'h0);
        checkVal("r4 drained data", readData1, 32'h00000055);
        checkVal("r4 drained scoreError", {31'b0, scoreError}, 32'h0);
        tick();

        // Overflow: fourth issue at count 3 sets the error and holds 3.
        issue_reading(5'd4, 1'b0, "r4 fill1");
        issue_reading(5'd4, 1'b1, "r4 fill2");
        issue_reading(5'd4, 1'b1, "r4 fill3");
        issue_reading(5'd4, 1'b1, "r4 overflow");
        idle();
        checkVal("overflow scoreError", {31'b0, scoreError}, 32'h1);
        wb_reading(5'd4, 32'h00000061, 1'b1, "r4 after ovf wb1");
        wb_reading(5'd4, 32'h00000062, 1'b1, "r4 after ovf wb2");
        wb_reading(5'd4, 32'h00000063, 1'b0, "r4 after ovf wb3");

        // Simultaneous issue + WB on r6, then underflow on a WB at count 0.
        do_reset();
        issue_reading(5'd6, 1'b0, "r6 issue");
        applyStimulus(1'b1, 5'd6, 32'h00000066, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        checkVal("r6 same-cycle stall", {31'b0, stall}, 32'h0);
        checkVal("r6 same-cycle bypass", readData1, 32'h00000066);
        checkOutput("r6 same-cycle");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkVal("r6 count held stall", {31'b0, stall}, 32'h1);
        checkVal("r6 count held scoreError", {31'b0, scoreError}, 32'h0);
        tick();
        wb_reading(5'd6, 32'h00000067, 1'b0, "r6 wb");
        wb_reading(5'd6, 32'h00000068, 1'b1, "r6 underflow wb");
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkVal("underflow scoreError", {31'b0, scoreError}, 32'h1);
        checkVal("underflow count zero stall", {31'b0, stall}, 32'h0);
        checkVal("underflow data", readData1, 32'h00000068);
        tick();

        // Randomized traffic on a small register window to provoke hazards.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            if (model_stall()) begin
                issueValid = 1'b0;
                #1;
            end
            checkOutput($sformatf("rand%0d", c));
            tick();
        end

        // Asynchronous reset mid-cycle after writing r5.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkVal("r5 before reset", readData1, 32'hDEADBEEF);
        checkOutput("r5 before reset");
        reset_n = 1'b0;
        #1;
        checkVal("async reset readData1", readData1, 32'h0);
        checkVal("async reset stall", {31'b0, stall}, 32'h0);
        checkVal("async reset scoreError", {31'b0, scoreError}, 32'h0);
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("after reset release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
